midi_voice_allocator: RTL and testbench

Upstream control stage for the synth voice path: parses a MIDI byte stream (from a UART receiver) and assigns note-on/note-off events to the four NCO voices. It drives the per-voice dividers consumed by `chanel_manager`, and holds each voice until its key is released. This replaces the SPI-based `main_state_machine` as the source of `VOICE_n_DIV`.

---
 rtl/midi_pkg.sv | 29 ++
 rtl/midi_note_div_rom.sv | 48 ++++
 rtl/midi_voice_allocator.sv | 230 +++++++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 529 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// midi_pkg: shared constants and types for the MIDI voice allocator.
// Status nibbles, controller numbers, parser states and command ops.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHAN_AT  = 4'hD;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    localparam int NOTE_LO_DEF = 44;
    localparam int NOTE_HI_DEF = 125;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_D1,
        WAIT_D2,
        SKIP1
    } parse_state_t;

    typedef enum logic [1:0] {
        OP_ON,
        OP_OFF,
        OP_CLR
    } cmd_op_t;

endpackage

// File: rtl/midi_note_div_rom.sv
// midi_note_div_rom: note number to NCO divider, one-cycle latency.
// Divider = round(12e6 / (256 * f_note)); unplayable notes read 0.
module midi_note_div_rom
    import midi_pkg::*;
#(
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [6:0]     addr,
    output logic [D_W-1:0] data
);

    localparam logic [8:0] TAB [NOTE_LO_DEF:NOTE_HI_DEF] = '{
        9'd451, 9'd426, 9'd402, 9'd380, 9'd358,
        9'd338, 9'd319, 9'd301, 9'd284, 9'd268,
        9'd253, 9'd239, 9'd226, 9'd213, 9'd201,
        9'd190, 9'd179, 9'd169, 9'd160, 9'd151,
        9'd142, 9'd134, 9'd127, 9'd120, 9'd113,
        9'd107, 9'd101, 9'd95,  9'd90,  9'd85,
        9'd80,  9'd75,  9'd71,  9'd67,  9'd63,
        9'd60,  9'd56,  9'd53,  9'd50,  9'd47,
        9'd45,  9'd42,  9'd40,  9'd38,  9'd36,
        9'd34,  9'd32,  9'd30,  9'd28,  9'd27,
        9'd25,  9'd24,  9'd22,  9'd21,  9'd20,
        9'd19,  9'd18,  9'd17,  9'd16,  9'd15,
        9'd14,  9'd13,  9'd13,  9'd12,  9'd11,
        9'd11,  9'd10,  9'd9,   9'd9,   9'd8,
        9'd8,   9'd7,   9'd7,   9'd7,   9'd6,
        9'd6,   9'd6,   9'd5,   9'd5,   9'd5,
        9'd4,   9'd4
    };

    logic in_tab;

    assign in_tab = int'(addr) >= NOTE_LO_DEF
                 && int'(addr) <= NOTE_HI_DEF;

    // Registered table read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= in_tab ? D_W'(TAB[addr]) : '0;
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: MIDI byte parser and 4-voice note allocator.
// Parse -> allocate (E1) -> divider write (E2), in-order pipeline.
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int D_W          = 16,
    parameter int NUM_VOICES   = 4,
    parameter int MIDI_CHANNEL = 0,
    parameter int NOTE_LO      = NOTE_LO_DEF,
    parameter int NOTE_HI      = NOTE_HI_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [D_W-1:0]        VOICE_0_DIV,
    output logic [D_W-1:0]        VOICE_1_DIV,
    output logic [D_W-1:0]        VOICE_2_DIV,
    output logic [D_W-1:0]        VOICE_3_DIV,
    output logic [NUM_VOICES-1:0] voice_active
);

    localparam int         VW   = $clog2(NUM_VOICES);
    localparam logic [3:0] CHAN = 4'(MIDI_CHANNEL);

    parse_state_t state, state_n;
    logic [3:0]   rs_nib, rs_nib_n;
    logic         rs_act, rs_act_n;
    logic [6:0]   d1, d1_n;

    logic is_rst, is_rt, is_sys, is_chan, is_data;
    logic [3:0] nib;

    logic    cmd_v, cmd_v_n;
    cmd_op_t cmd_op, cmd_op_n;
    logic [6:0] cmd_note, cmd_note_n;

    logic [6:0]    note [NUM_VOICES];
    logic          free_hit, match_hit, in_range;
    logic [VW-1:0] free_idx, match_idx;

    logic          wr_v, wr_clr, wr_load;
    logic [VW-1:0] wr_idx;
    logic [D_W-1:0] rom_q;
    logic [D_W-1:0] div [NUM_VOICES];

    assign nib     = rx_byte[7:4];
    assign is_data = ~rx_byte[7];
    assign is_rst  = rx_byte == 8'hFF;
    assign is_rt   = rx_byte[7:3] == 5'h1F && !is_rst;
    assign is_sys  = rx_byte[7:3] == 5'h1E;
    assign is_chan = rx_byte[7] && nib != 4'hF;

    // Parser next state and command decode.
    always_comb begin
        state_n    = state;
        rs_nib_n   = rs_nib;
        rs_act_n   = rs_act;
        d1_n       = d1;
        cmd_v_n    = 1'b0;
        cmd_op_n   = OP_CLR;
        cmd_note_n = d1;
        if (rx_valid) begin
            unique case (1'b1)
                is_rst: begin
                    state_n  = IDLE;
                    rs_act_n = 1'b0;
                    cmd_v_n  = 1'b1;
                end
                is_rt: ;
                is_sys: begin
                    state_n  = IDLE;
                    rs_act_n = 1'b0;
                end
                is_chan: begin
                    rs_nib_n = nib;
                    rs_act_n = rx_byte[3:0] == CHAN
                            && (nib == ST_NOTE_OFF
                             || nib == ST_NOTE_ON
                             || nib == ST_CC);
                    state_n  = (nib == ST_PROG || nib == ST_CHAN_AT)
                             ? SKIP1 : WAIT_D1;
                end
                is_data: begin
                    unique case (state)
                        IDLE, SKIP1: ;
                        WAIT_D1: begin
                            d1_n    = rx_byte[6:0];
                            state_n = WAIT_D2;
                        end
                        WAIT_D2: begin
                            state_n = WAIT_D1;
                            if (rs_act) begin
                                case (rs_nib)
                                    ST_NOTE_OFF: begin
                                        cmd_v_n  = 1'b1;
                                        cmd_op_n = OP_OFF;
                                    end
                                    ST_NOTE_ON: begin
                                        cmd_v_n  = 1'b1;
                                        cmd_op_n = (rx_byte[6:0] != 7'd0)
                                                 ? OP_ON : OP_OFF;
                                    end
                                    ST_CC: begin
                                        cmd_v_n = d1 == CC_ALL_NOTES_OFF;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Parser state and issued-command register (edge E0).
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rs_nib   <= '0;
            rs_act   <= 1'b0;
            d1       <= '0;
            cmd_v    <= 1'b0;
            cmd_op   <= OP_CLR;
            cmd_note <= '0;
        end else begin
            state    <= state_n;
            rs_nib   <= rs_nib_n;
            rs_act   <= rs_act_n;
            d1       <= d1_n;
            cmd_v    <= cmd_v_n;
            cmd_op   <= cmd_op_n;
            cmd_note <= cmd_note_n;
        end
    end

    assign in_range = int'(cmd_note) >= NOTE_LO
                   && int'(cmd_note) <= NOTE_HI;

    // Lowest free voice and lowest voice already holding the note.
    always_comb begin
        free_hit  = 1'b0;
        free_idx  = '0;
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!voice_active[i]) begin
                free_hit = 1'b1;
                free_idx = VW'(i);
            end
            if (voice_active[i] && note[i] == cmd_note) begin
                match_hit = 1'b1;
                match_idx = VW'(i);
            end
        end
    end

    // Voice allocation and divider-write request (edge E1).
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            voice_active <= '0;
            for (int i = 0; i < NUM_VOICES; i++) note[i] <= '0;
            wr_v    <= 1'b0;
            wr_clr  <= 1'b0;
            wr_load <= 1'b0;
            wr_idx  <= '0;
        end else begin
            wr_v    <= 1'b0;
            wr_clr  <= 1'b0;
            wr_load <= 1'b0;
            if (cmd_v) begin
                unique case (cmd_op)
                    OP_ON: begin
                        if (in_range && !match_hit && free_hit) begin
                            voice_active[free_idx] <= 1'b1;
                            note[free_idx]         <= cmd_note;
                            wr_v    <= 1'b1;
                            wr_load <= 1'b1;
                            wr_idx  <= free_idx;
                        end
                    end
                    OP_OFF: begin
                        if (match_hit) begin
                            voice_active[match_idx] <= 1'b0;
                            wr_v   <= 1'b1;
                            wr_idx <= match_idx;
                        end
                    end
                    OP_CLR: begin
                        voice_active <= '0;
                        wr_v   <= 1'b1;
                        wr_clr <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    midi_note_div_rom #(
        .D_W (D_W)
    ) u_rom (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .addr  (cmd_note),
        .data  (rom_q)
    );

    // Divider write-back, strictly in command order (edge E2).
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) div[i] <= '0;
        end else if (wr_v) begin
            if (wr_clr) begin
                for (int i = 0; i < NUM_VOICES; i++) div[i] <= '0;
            end else begin
                div[wr_idx] <= wr_load ? rom_q : '0;
            end
        end
    end

    assign VOICE_0_DIV = div[0];
    assign VOICE_1_DIV = div[1];
    assign VOICE_2_DIV = div[2];
    assign VOICE_3_DIV = div[3];

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: directed and randomized MIDI streams
// checked against a message-level voice model.
module tb_midi_voice_allocator;

    typedef logic [7:0] bq_t [$];

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [15:0] v0, v1, v2, v3;
    logic [3:0]  voice_active;
    logic [15:0] dd [4];

    int n_cmp = 0;
    int n_err = 0;

    bit         m_act [4];
    int         m_note [4];
    int         m_div [4];
    bit         m_rs_v;
    logic [7:0] m_rs;
    bit         m_have_d1;
    int         m_d1;

    midi_voice_allocator dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .VOICE_0_DIV  (v0),
        .VOICE_1_DIV  (v1),
        .VOICE_2_DIV  (v2),
        .VOICE_3_DIV  (v3),
        .voice_active (voice_active)
    );

    assign dd[0] = v0;
    assign dd[1] = v1;
    assign dd[2] = v2;
    assign dd[3] = v3;

    always #10 sys_clk = ~sys_clk;

    function automatic int ref_div(int n);
        real f;
        f = 440.0 * (2.0 ** ((n - 69) / 12.0));
        return $rtoi(12.0e6 / (256.0 * f) + 0.5);
    endfunction

    function automatic logic [3:0] m_act_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_act[i];
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 1'b0;
            m_div[i] = 0;
        end
    endtask

    task automatic m_reset();
        m_clear();
        for (int i = 0; i < 4; i++) m_note[i] = 0;
        m_rs_v = 1'b0;
        m_rs = 8'h00;
        m_have_d1 = 1'b0;
        m_d1 = 0;
    endtask

    task automatic m_on(int n);
        int slot = -1;
        if (n < 44 || n > 125) return;
        for (int i = 0; i < 4; i++)
            if (m_act[i] && m_note[i] == n) return;
        for (int i = 3; i >= 0; i--)
            if (!m_act[i]) slot = i;
        if (slot < 0) return;
        m_act[slot] = 1'b1;
        m_note[slot] = n;
        m_div[slot] = ref_div(n);
    endtask

    task automatic m_off(int n);
        for (int i = 0; i < 4; i++)
            if (m_act[i] && m_note[i] == n) begin
                m_act[i] = 1'b0;
                m_div[i] = 0;
            end
    endtask

    task automatic m_byte(logic [7:0] b);
        if (b == 8'hFF) begin
            m_clear();
            m_rs_v = 1'b0;
            m_have_d1 = 1'b0;
        end else if (b >= 8'hF8) begin
        end else if (b >= 8'hF0) begin
            m_rs_v = 1'b0;
            m_have_d1 = 1'b0;
        end else if (b >= 8'h80) begin
            m_rs_v = 1'b1;
            m_rs = b;
            m_have_d1 = 1'b0;
        end else if (m_rs_v && m_rs[7:4] != 4'hC && m_rs[7:4] != 4'hD) begin
            if (!m_have_d1) begin
                m_d1 = int'(b);
                m_have_d1 = 1'b1;
            end else begin
                m_have_d1 = 1'b0;
                if (m_rs[3:0] == 4'h0) begin
                    case (m_rs[7:4])
                        4'h8: m_off(m_d1);
                        4'h9: if (b != 8'h00) m_on(m_d1); else m_off(m_d1);
                        4'hB: if (m_d1 == 123) m_clear();
                        default: ;
                    endcase
                end
            end
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        @(negedge sys_clk);
        rx_byte = b;
        rx_valid = 1'b1;
        m_byte(b);
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(bq_t q);
        foreach (q[k]) send_byte(q[k]);
    endtask

    task automatic stream(bq_t q);
        foreach (q[k]) begin
            @(negedge sys_clk);
            rx_byte = q[k];
            rx_valid = 1'b1;
            m_byte(q[k]);
        end
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        m_reset();
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        m_reset();
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if (voice_active !== 4'b0000) begin
            n_err++;
            $display("FAIL reset active: got %b want 0000", voice_active);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dd[i] !== 16'd0) begin
                n_err++;
                $display("FAIL reset div%0d: got %0d want 0", i, dd[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_note_on_timing();
        send_byte(8'h90);
        send_byte(8'h45);
        send_byte(8'h64);
        n_cmp++;
        if (voice_active !== 4'b0000) begin
            n_err++;
            $display("FAIL a4 pre-E1 active: got %b want 0000", voice_active);
        end
        @(negedge sys_clk);
        n_cmp++;
        if (voice_active !== 4'b0001) begin
            n_err++;
            $display("FAIL a4 E1 active: got %b want 0001", voice_active);
        end
        n_cmp++;
        if (v0 !== 16'd0) begin
            n_err++;
            $display("FAIL a4 E1 div0: got %0d want 0", v0);
        end
        @(negedge sys_clk);
        n_cmp++;
        if (v0 !== 16'd107) begin
            n_err++;
            $display("FAIL a4 E2 div0: got %0d want 107", v0);
        end
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (dd[i] !== 16'd0) begin
                n_err++;
                $display("FAIL a4 E2 div%0d: got %0d want 0", i, dd[i]);
            end
        end
    endtask

    task automatic test_running_status();
        send_seq('{8'h3C, 8'h50});
        settle();
        n_cmp++;
        if (voice_active !== 4'b0011) begin
            n_err++;
            $display("FAIL rs on active: got %b want 0011", voice_active);
        end
        n_cmp++;
        if (v1 !== 16'd179) begin
            n_err++;
            $display("FAIL rs on div1: got %0d want 179", v1);
        end
        send_seq('{8'h3C, 8'h00});
        settle();
        n_cmp++;
        if (voice_active !== 4'b0001) begin
            n_err++;
            $display("FAIL rs off active: got %b want 0001", voice_active);
        end
        n_cmp++;
        if (v1 !== 16'd0 || v0 !== 16'd107) begin
            n_err++;
            $display("FAIL rs off divs: got %0d/%0d want 107/0", v0, v1);
        end
    endtask

    task automatic test_range_dup();
        do_reset();
        send_seq('{8'h90, 8'h2B, 8'h40});
        settle();
        n_cmp++;
        if (voice_active !== 4'b0000) begin
            n_err++;
            $display("FAIL range lo-1 active: got %b want 0000", voice_active);
        end
        send_seq('{8'h90, 8'h2C, 8'h40});
        settle();
        n_cmp++;
        if (v0 !== 16'd451) begin
            n_err++;
            $display("FAIL range lo div0: got %0d want 451", v0);
        end
        send_seq('{8'h90, 8'h7D, 8'h40});
        settle();
        n_cmp++;
        if (v1 !== 16'd4) begin
            n_err++;
            $display("FAIL range hi div1: got %0d want 4", v1);
        end
        send_seq('{8'h90, 8'h7E, 8'h40, 8'h2C, 8'h40});
        settle();
        n_cmp++;
        if (voice_active !== m_act_vec()) begin
            n_err++;
            $display("FAIL dup active: got %b want %b",
                     voice_active, m_act_vec());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dd[i] !== 16'(m_div[i])) begin
                n_err++;
                $display("FAIL dup div%0d: got %0d want %0d",
                         i, dd[i], m_div[i]);
            end
        end
    endtask

    task automatic test_full_alloc();
        do_reset();
        send_seq('{8'h90, 8'd50, 8'h40, 8'd52, 8'h40, 8'd55, 8'h40,
                   8'd57, 8'h40, 8'd60, 8'h40});
        settle();
        n_cmp++;
        if (voice_active !== 4'b1111) begin
            n_err++;
            $display("FAIL full active: got %b want 1111", voice_active);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dd[i] !== 16'(m_div[i])) begin
                n_err++;
                $display("FAIL full div%0d: got %0d want %0d",
                         i, dd[i], m_div[i]);
            end
        end
        send_seq('{8'h80, 8'd55, 8'h00});
        settle();
        n_cmp++;
        if (voice_active !== 4'b1011 || v2 !== 16'd0) begin
            n_err++;
            $display("FAIL full off: got %b/%0d want 1011/0",
                     voice_active, v2);
        end
        send_seq('{8'h90, 8'd62, 8'h40});
        settle();
        n_cmp++;
        if (voice_active !== 4'b1111 || v2 !== 16'(ref_div(62))) begin
            n_err++;
            $display("FAIL full reuse: got %b/%0d want 1111/%0d",
                     voice_active, v2, ref_div(62));
        end
    endtask

    task automatic test_interleaved();
        do_reset();
        send_seq('{8'h90, 8'h3C, 8'hF8, 8'h50});
        settle();
        n_cmp++;
        if (voice_active !== 4'b0001 || v0 !== 16'd179) begin
            n_err++;
            $display("FAIL rt between: got %b/%0d want 0001/179",
                     voice_active, v0);
        end
        send_seq('{8'h90, 8'h3E, 8'hF0, 8'h40, 8'h3E, 8'h40});
        send_seq('{8'h91, 8'h40, 8'h40, 8'hC0, 8'h05, 8'h3C, 8'h40});
        settle();
        n_cmp++;
        if (voice_active !== 4'b0001) begin
            n_err++;
            $display("FAIL discard active: got %b want 0001", voice_active);
        end
        send_seq('{8'h90, 8'h45, 8'h90, 8'h47, 8'h50});
        settle();
        n_cmp++;
        if (voice_active !== 4'b0011 || v1 !== 16'd95) begin
            n_err++;
            $display("FAIL abort d2: got %b/%0d want 0011/95",
                     voice_active, v1);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dd[i] !== 16'(m_div[i])) begin
                n_err++;
                $display("FAIL interleave div%0d: got %0d want %0d",
                         i, dd[i], m_div[i]);
            end
        end
    endtask

    task automatic test_all_clear();
        do_reset();
        send_seq('{8'h90, 8'h40, 8'h40, 8'h42, 8'h40, 8'h44, 8'h40});
        settle();
        n_cmp++;
        if (voice_active !== 4'b0111) begin
            n_err++;
            $display("FAIL clr setup: got %b want 0111", voice_active);
        end
        send_seq('{8'hB0, 8'h7B, 8'h00});
        @(negedge sys_clk);
        n_cmp++;
        if (voice_active !== 4'b0000 || v0 !== 16'(ref_div(64))) begin
            n_err++;
            $display("FAIL cc123 E1: got %b/%0d want 0000/%0d",
                     voice_active, v0, ref_div(64));
        end
        @(negedge sys_clk);
        n_cmp++;
        if ({v0, v1, v2, v3} !== 64'd0) begin
            n_err++;
            $display("FAIL cc123 E2: got %0d %0d %0d want 0",
                     v0, v1, v2);
        end
        send_seq('{8'h90, 8'h40, 8'h40, 8'h42, 8'h40});
        settle();
        send_byte(8'hFF);
        @(negedge sys_clk);
        n_cmp++;
        if (voice_active !== 4'b0000) begin
            n_err++;
            $display("FAIL ff E1: got %b want 0000", voice_active);
        end
        @(negedge sys_clk);
        n_cmp++;
        if ({v0, v1, v2, v3} !== 64'd0) begin
            n_err++;
            $display("FAIL ff E2: got %0d %0d want 0", v0, v1);
        end
        send_seq('{8'h41, 8'h40, 8'h43, 8'h40});
        settle();
        n_cmp++;
        if (voice_active !== 4'b0000) begin
            n_err++;
            $display("FAIL ff idle: got %b want 0000", voice_active);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        stream('{8'h90, 8'h3C, 8'h50, 8'hFF});
        settle();
        n_cmp++;
        if (voice_active !== 4'b0000 || v0 !== 16'd0) begin
            n_err++;
            $display("FAIL b2b ff: got %b/%0d want 0000/0",
                     voice_active, v0);
        end
        stream('{8'h90, 8'h3C, 8'h50, 8'h3E, 8'h50, 8'h3C, 8'h00,
                 8'h3C, 8'h50, 8'h40, 8'h50, 8'h3E, 8'h00});
        settle();
        n_cmp++;
        if (voice_active !== m_act_vec()) begin
            n_err++;
            $display("FAIL b2b active: got %b want %b",
                     voice_active, m_act_vec());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dd[i] !== 16'(m_div[i])) begin
                n_err++;
                $display("FAIL b2b div%0d: got %0d want %0d",
                         i, dd[i], m_div[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_seq('{8'h90, 8'h3C});
        do_reset();
        send_byte(8'h50);
        settle();
        n_cmp++;
        if (voice_active !== 4'b0000) begin
            n_err++;
            $display("FAIL rst partial: got %b want 0000", voice_active);
        end
        send_seq('{8'h90, 8'h3C, 8'h50});
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        settle();
        n_cmp++;
        if (voice_active !== 4'b0000 || v0 !== 16'd0) begin
            n_err++;
            $display("FAIL rst inflight: got %b/%0d want 0000/0",
                     voice_active, v0);
        end
    endtask

    task automatic test_random();
        int r, r2, len;
        logic [7:0] b;
        bit vld;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            len = int'($urandom_range(8, 24));
            for (int k = 0; k < len; k++) begin
                r = int'($urandom_range(0, 99));
                r2 = int'($urandom_range(0, 99));
                if (r < 55) begin
                    if (r2 < 15) b = 8'd0;
                    else if (r2 < 20) b = 8'd123;
                    else if (r2 < 25) b = 8'd43;
                    else if (r2 < 30) b = 8'd125;
                    else b = 8'($urandom_range(44, 54));
                end else if (r < 75) b = 8'h90;
                else if (r < 83) b = 8'h80;
                else if (r < 86) b = 8'hB0;
                else if (r < 88) b = 8'h91;
                else if (r < 90) b = 8'hC0;
                else if (r < 91) b = 8'hA0;
                else if (r < 94) b = 8'hF8;
                else if (r < 96) b = 8'hF0;
                else if (r < 97) b = 8'hFF;
                else b = 8'($urandom_range(128, 255));
                vld = ($urandom_range(0, 3) != 0);
                @(negedge sys_clk);
                rx_byte = b;
                rx_valid = vld;
                if (vld) m_byte(b);
            end
            @(negedge sys_clk);
            rx_valid = 1'b0;
            settle();
            n_cmp++;
            if (voice_active !== m_act_vec()) begin
                n_err++;
                $display("FAIL rnd%0d active: got %b want %b",
                         c, voice_active, m_act_vec());
            end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (dd[i] !== 16'(m_div[i])) begin
                    n_err++;
                    $display("FAIL rnd%0d div%0d: got %0d want %0d",
                             c, i, dd[i], m_div[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_note_on_timing();
        test_running_status();
        test_range_dup();
        test_full_alloc();
        test_interleaved();
        test_all_clear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
